// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with a per-grant hold timer and one turnaround cycle between owners.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m1 has fixed priority.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m1_done,
  input  logic       m2_done,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] bus_owner,
  output logic       bus_busy,
  output logic       timeout_pulse,
  output logic [7:0] timeout_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt1 = 2'b01,
    StGnt2 = 2'b10,
    StTurn = 2'b11
  } state_e;

  state_e            state_q, state_d, arb_win;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        timeout_count_q, timeout_count_d;
  logic              hold_expired;

  assign hold_expired = (hold_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = m2 was the most recent owner.
  logic last_owner_q, last_owner_d;

  always_comb begin
    arb_win = StIdle;
    if (m1_req && m2_req) begin
      arb_win = last_owner_q ? StGnt1 : StGnt2;
    end else if (m1_req) begin
      arb_win = StGnt1;
    end else if (m2_req) begin
      arb_win = StGnt2;
    end
  end
`else
  always_comb begin
    arb_win = StIdle;
    if (m1_req) begin
      arb_win = StGnt1;
    end else if (m2_req) begin
      arb_win = StGnt2;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle, StTurn: state_d = arb_win;
      StGnt1: begin
        if (m1_done || !m1_req) begin
          state_d = StTurn;
        end else if (hold_expired) begin
          state_d   = StTurn;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StGnt2: begin
        if (m2_done || !m2_req) begin
          state_d = StTurn;
        end else if (hold_expired) begin
          state_d   = StTurn;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    timeout_count_d = timeout_count_q;
    if (timeout_d && (timeout_count_q != 8'hFF)) begin
      timeout_count_d = timeout_count_q + 8'd1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == StIdle) || (state_q == StTurn)) begin
      if (state_d == StGnt1) begin
        last_owner_d = 1'b0;
      end else if (state_d == StGnt2) begin
        last_owner_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      hold_cnt_q      <= '0;
      timeout_q       <= 1'b0;
      timeout_count_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      timeout_q       <= timeout_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign m1_grant      = (state_q == StGnt1);
  assign m2_grant      = (state_q == StGnt2);
  assign bus_owner     = {m2_grant, m1_grant};
  assign bus_busy      = m1_grant | m2_grant;
  assign timeout_pulse = timeout_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: driver pushes model expectations, monitor pops and compares.
module tb_bus_arbiter;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m1_req = 1'b0, m2_req = 1'b0, m1_done = 1'b0, m2_done = 1'b0;
  logic       m1_grant, m2_grant, bus_busy, timeout_pulse;
  logic [1:0] bus_owner;
  logic [7:0] timeout_count;

  bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .m1_req       (m1_req),
    .m2_req       (m2_req),
    .m1_done      (m1_done),
    .m2_done      (m2_done),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .bus_owner    (bus_owner),
    .bus_busy     (bus_busy),
    .timeout_pulse(timeout_pulse),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g1;
    logic       g2;
    logic [1:0] own;
    logic       busy;
    logic       pulse;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // Reference model: who owns the bus, for how many cycles, and the timeout tally.
  int m_owner, m_held, m_last, m_cnt;
  bit m_pulse;

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_last = 2; m_cnt = 0; m_pulse = 0;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.g1    = (m_owner == 1);
    o.g2    = (m_owner == 2);
    o.own   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    o.busy  = (m_owner != 0);
    o.pulse = m_pulse;
    o.cnt   = m_cnt[7:0];
    return o;
  endfunction

  task automatic model_step(input bit r1, input bit r2, input bit d1, input bit d2);
    bit dn, rq;
    int win;
    m_pulse = 0;
    if (m_owner != 0) begin
      dn = (m_owner == 1) ? d1 : d2;
      rq = (m_owner == 1) ? r1 : r2;
      if (dn || !rq) begin
        m_owner = 0;
      end else if (m_held == T) begin
        m_owner = 0;
        m_pulse = 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_held++;
      end
    end else begin
      win = 0;
      if (r1 && r2) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = (m_last == 1) ? 2 : 1;
`else
        win = 1;
`endif
      end else if (r1) begin
        win = 1;
      end else if (r2) begin
        win = 2;
      end
      if (win != 0) begin
        m_owner = win; m_held = 1; m_last = win;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input bit r1, input bit r2, input bit d1, input bit d2);
    m1_req = r1; m2_req = r2; m1_done = d1; m2_done = d2;
    model_step(r1, r2, d1, d2);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    obs_t e, g;
    cycle++;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {m1_grant, m2_grant, bus_owner, bus_busy, timeout_pulse, timeout_count};
      check("outputs{g1,g2,own,busy,pulse,cnt}", 32'(g), 32'(e));
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, " m1_grant"}, 32'(m1_grant), 32'd0);
    check({name, " m2_grant"}, 32'(m2_grant), 32'd0);
    check({name, " bus_owner"}, 32'(bus_owner), 32'd0);
    check({name, " bus_busy"}, 32'(bus_busy), 32'd0);
    check({name, " timeout_pulse"}, 32'(timeout_pulse), 32'd0);
    check({name, " timeout_count"}, 32'(timeout_count), 32'd0);
  endtask

  initial begin
    bit want1, want2, d1, d2;
    model_reset();
    m1_req = 1'b1; m2_req = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #3;
    check_reset_outputs("reset held");
    reset = 1'b1;

    // Tie right after reset: m1 wins in both modes.
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // m2 alone, done on its 3rd grant cycle.
    for (int i = 0; i < 6; i++) step(0, (i < 4), 0, (m_owner == 2 && m_held == 3));

    // Both wait, no done: m1 times out, m2 follows after TURN.
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Both hold requests, done on the 2nd grant cycle of each.
    for (int i = 0; i < 20; i++) step(1, 1, (m_owner == 1 && m_held == 2),
                                        (m_owner == 2 && m_held == 2));

    // Done coincides with the hold-timer expiry.
    for (int i = 0; i < 2 * T + 4; i++) step(1, 0, (m_owner == 1 && m_held == T), 0);

    // Spurious done pulses outside a grant.
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

    // Randomised masters, frequent then rare done.
    want1 = 0; want2 = 0;
    for (int i = 0; i < 1200; i++) begin
      int pd;
      pd = (i < 600) ? 3 : 40;
      if (!want1 && $urandom_range(0, 3) == 0) want1 = 1;
      if (!want2 && $urandom_range(0, 3) == 0) want2 = 1;
      d1 = (m_owner == 1) ? ($urandom_range(0, pd) == 0) : ($urandom_range(0, 7) == 0);
      d2 = (m_owner == 2) ? ($urandom_range(0, pd) == 0) : ($urandom_range(0, 7) == 0);
      step(want1, want2, d1, d2);
      if (d1 || $urandom_range(0, 31) == 0) want1 = $urandom_range(0, 1);
      if (d2 || $urandom_range(0, 31) == 0) want2 = $urandom_range(0, 1);
    end

    // Drive the timeout counter into saturation.
    for (int i = 0; i < 262 * (T + 1); i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Async reset in the middle of an m1 grant, between edges.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("m1 granted before async reset", 32'(m1_grant), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, (m_owner == 1 && m_held == 2),
                                       (m_owner == 2 && m_held == 2));

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
